// File: rtl/fret_link_tx.sv
// Pmod fret link transmitter: serializes {seq, fret, strum, parity} words on clock/data/frame
// and resends the last word as a keep-alive after a configurable idle time.
module fret_link_tx #(
  parameter int unsigned CLK_DIV   = 50,
  parameter int unsigned GAP_BITS  = 2,
  parameter int unsigned KEEPALIVE = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fret_valid,
  input  logic [4:0] fret,
  input  logic       strum,
  output logic       fret_ready,
  output logic       link_clk,
  output logic       link_data,
  output logic       link_frame,
  output logic       busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned KA_W  = $clog2(KEEPALIVE + 1);
  localparam int unsigned GAP_W = $clog2(GAP_BITS + 2);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [KA_W-1:0]  KA_LIMIT = KA_W'(KEEPALIVE);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic             phase, phase_nxt;
  logic [3:0]       bit_idx, bit_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [KA_W-1:0]  ka_cnt, ka_nxt;
  logic [3:0]       seq, seq_nxt;
  logic             sent_any, sent_nxt;
  logic [15:0]      shreg, shreg_nxt;
  logic             link_clk_nxt, link_data_nxt, link_frame_nxt, busy_nxt;

  logic        half_end, bit_end, accept, ka_due;
  logic [15:0] word_new;

  assign fret_ready = (state == IDLE);
  assign half_end   = (div_cnt == DIV_LAST);
  assign bit_end    = half_end && phase;
  assign accept     = fret_valid && (state == IDLE);
  assign ka_due     = bit_end && sent_any && ((ka_cnt + KA_W'(1)) == KA_LIMIT);
  assign word_new   = {seq, fret, strum, 5'b0_0000, ^{seq, fret, strum}};

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    div_nxt        = half_end ? '0 : div_cnt + DIV_W'(1);
    phase_nxt      = half_end ? ~phase : phase;
    bit_nxt        = bit_idx;
    gap_nxt        = gap_cnt;
    ka_nxt         = ka_cnt;
    seq_nxt        = seq;
    sent_nxt       = sent_any;
    shreg_nxt      = shreg;
    link_clk_nxt   = 1'b0;
    link_data_nxt  = 1'b0;
    link_frame_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (bit_end && (ka_cnt != KA_LIMIT)) ka_nxt = ka_cnt + KA_W'(1);
        // A fresh sample takes priority over a keep-alive due on the same edge
        if (accept || ka_due) begin
          state_nxt      = SHIFT;
          div_nxt        = '0;
          phase_nxt      = 1'b0;
          bit_nxt        = 4'd15;
          ka_nxt         = '0;
          link_frame_nxt = 1'b1;
          link_data_nxt  = accept ? word_new[15] : shreg[15];
          if (accept) begin
            shreg_nxt = word_new;
            seq_nxt   = seq + 4'd1;
            sent_nxt  = 1'b1;
          end
        end
      end
      SHIFT: begin
        link_frame_nxt = 1'b1;
        link_clk_nxt   = link_clk;
        link_data_nxt  = link_data;
        if (half_end) begin
          if (!phase) begin
            link_clk_nxt = 1'b1;
          end else begin
            // Rotate so the word is intact again after 16 bits, ready for a keep-alive
            link_clk_nxt = 1'b0;
            shreg_nxt    = {shreg[14:0], shreg[15]};
            if (bit_idx == 4'd0) begin
              link_frame_nxt = 1'b0;
              link_data_nxt  = 1'b0;
              gap_nxt        = '0;
              state_nxt      = (GAP_BITS == 0) ? IDLE : GAP;
            end else begin
              bit_nxt       = bit_idx - 4'd1;
              link_data_nxt = shreg[14];
            end
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (gap_cnt == GAP_LAST) state_nxt = IDLE;
          else                     gap_nxt   = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      phase      <= 1'b0;
      bit_idx    <= 4'd0;
      gap_cnt    <= '0;
      ka_cnt     <= '0;
      seq        <= 4'd0;
      sent_any   <= 1'b0;
      shreg      <= 16'd0;
      link_clk   <= 1'b0;
      link_data  <= 1'b0;
      link_frame <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      phase      <= phase_nxt;
      bit_idx    <= bit_nxt;
      gap_cnt    <= gap_nxt;
      ka_cnt     <= ka_nxt;
      seq        <= seq_nxt;
      sent_any   <= sent_nxt;
      shreg      <= shreg_nxt;
      link_clk   <= link_clk_nxt;
      link_data  <= link_data_nxt;
      link_frame <= link_frame_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule
